// File: rtl/adder8_seq_ctrl.sv
// Byte-serial add/sub sequencer: drives a shared external 8-bit adder slice
// by slice (low byte first), chaining the carry in a register between slices.
module adder8_seq_ctrl #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                sub,
   input  logic [8*NBYTES-1:0] op_a,
   input  logic [8*NBYTES-1:0] op_b,
   output logic                busy,
   output logic                done,
   output logic [8*NBYTES-1:0] result,
   output logic                carry,
   output logic                overflow,
   output logic                zero,
   output logic [7:0]          add_a,
   output logic [7:0]          add_b,
   output logic                add_cin,
   input  logic [7:0]          add_sum,
   input  logic                add_cout
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    a_reg, b_reg, res_nxt;
   logic            sub_reg, c_reg;
   logic [IW-1:0]   idx;
   logic            accept, last;

   assign last = (idx == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no latch can be inferred.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      add_a     = 8'h00;
      add_b     = 8'h00;
      add_cin   = 1'b0;
      case (state)
         IDLE: if (start) begin
            accept    = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            busy    = 1'b1;
            add_a   = a_reg[8*idx +: 8];
            add_b   = b_reg[8*idx +: 8];
            add_cin = (idx == '0) ? sub_reg : c_reg;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Result with the current slice merged in; the zero flag needs the final byte too.
   always_comb begin
      res_nxt              = result;
      res_nxt[8*idx +: 8]  = add_sum;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg    <= '0;
         b_reg    <= '0;
         sub_reg  <= 1'b0;
         c_reg    <= 1'b0;
         idx      <= '0;
         result   <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else if (accept) begin
         a_reg    <= op_a;
         b_reg    <= sub ? ~op_b : op_b;
         sub_reg  <= sub;
         c_reg    <= 1'b0;
         idx      <= '0;
         result   <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else if (state == RUN) begin
         result <= res_nxt;
         c_reg  <= add_cout;
         idx    <= last ? '0 : idx + IW'(1);
         if (last) begin
            carry    <= add_cout;
            overflow <= (a_reg[W-1] == b_reg[W-1]) & (add_sum[7] != a_reg[W-1]);
            zero     <= (res_nxt == '0);
         end
      end
   end

endmodule
